// File: rtl/code_lock_ctrl_pkg.sv
// Shared types and width helpers for the sequential code lock.
package code_lock_pkg;

  // Status encoding driven onto the status port and decoded by the HEX display
  typedef enum logic [2:0] {
    ST_ENTER   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } status_e;

  // Width of a counter that must hold the values 0..n inclusive
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of a down-counter that is loaded with n-1 and counts to 0
  function automatic int tmr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/code_lock_ctrl_if.sv
// Key/switch inputs and display-side outputs of the code lock.
interface code_lock_if
  import code_lock_pkg::*;
#(
  parameter int SEQ_LEN   = 6,
  parameter int DIGIT_W   = 4,
  parameter int MAX_TRIES = 3
);
  localparam int PW = cnt_w(SEQ_LEN);
  localparam int FW = cnt_w(MAX_TRIES);

  logic               enter;
  logic               clear;
  logic               prog;
  logic [DIGIT_W-1:0] digit;
  logic [2:0]         status;
  logic [PW-1:0]      pos;
  logic [FW-1:0]      fail_cnt;
  logic [DIGIT_W-1:0] disp_digit;
  logic               disp_valid;
  logic               unlocked;

  // Board side: drives the keys, watches the status
  modport master (
    output enter, clear, prog, digit,
    input  status, pos, fail_cnt, disp_digit, disp_valid, unlocked
  );

  // Lock controller side
  modport slave (
    input  enter, clear, prog, digit,
    output status, pos, fail_cnt, disp_digit, disp_valid, unlocked
  );
endinterface

// File: rtl/code_lock_ctrl_timer.sv
// Loadable down-counter that times the lockout dwell.
module lockout_timer
  import code_lock_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 16,
  localparam int TW = tmr_w(LOCKOUT_CYCLES)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          busy,
  output logic          done
);
  logic [TW-1:0] cnt;

  // Load wins; otherwise count down while busy and drop busy after the zero cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      busy <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      busy <= 1'b1;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - TW'(1);
    end
  end

  // done marks the last cycle of the dwell
  assign done = busy && (cnt == '0);
endmodule

// File: rtl/code_lock_ctrl.sv
// Parametrised combination lock: digit entry, reprogramming, retry count, lockout.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int SEQ_LEN        = 6,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [SEQ_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h483815
)(
  input logic        clk,
  input logic        rst,
  code_lock_if.slave bus
);
  localparam int PW = cnt_w(SEQ_LEN);
  localparam int FW = cnt_w(MAX_TRIES);
  localparam int TW = tmr_w(LOCKOUT_CYCLES);
  localparam int CW = SEQ_LEN * DIGIT_W;

  status_e            status_q;
  logic [PW-1:0]      pos_q;
  logic [FW-1:0]      fail_q;
  logic [DIGIT_W-1:0] disp_digit_q;
  logic               disp_valid_q;
  logic               unlocked_q;
  logic               bad_q;
  logic [CW-1:0]      code_q;
  logic [CW-1:0]      shadow_q;

  logic [DIGIT_W-1:0] exp_digit;
  logic [CW-1:0]      shadow_nxt;
  logic               last;
  logic               bad_nxt;
  logic               lock_hit;
  logic               tmr_load;
  logic               tmr_busy;
  logic               tmr_done;

  // Slice select for the current position; digit 0 sits in the MSBs
  always_comb begin
    exp_digit  = '0;
    shadow_nxt = shadow_q;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (pos_q == PW'(i)) begin
        exp_digit = code_q[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W];
        shadow_nxt[(SEQ_LEN-1-i)*DIGIT_W +: DIGIT_W] = bus.digit;
      end
    end
    last     = (pos_q == PW'(SEQ_LEN-1));
    bad_nxt  = bad_q | (bus.digit != exp_digit);
    lock_hit = ((fail_q + FW'(1)) == FW'(MAX_TRIES));
    // Timer must load on the same edge that moves into LOCKOUT
    tmr_load = (status_q == ST_ENTER) && bus.enter && !bus.clear &&
               last && bad_nxt && lock_hit;
  end

  lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TW'(LOCKOUT_CYCLES-1)),
    .busy     (tmr_busy),
    .done     (tmr_done)
  );

  // Main lock FSM; every output is a register updated on the strobe edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q     <= ST_ENTER;
      pos_q        <= '0;
      fail_q       <= '0;
      disp_digit_q <= '0;
      disp_valid_q <= 1'b0;
      unlocked_q   <= 1'b0;
      bad_q        <= 1'b0;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= '0;
    end else begin
      case (status_q)
        ST_ENTER: begin
          if (bus.clear) begin
            pos_q        <= '0;
            bad_q        <= 1'b0;
            disp_valid_q <= 1'b0;
          end else if (bus.enter) begin
            disp_digit_q <= bus.digit;
            disp_valid_q <= 1'b1;
            if (last) begin
              // Verdict only after the full sequence, including this digit
              pos_q <= '0;
              bad_q <= 1'b0;
              if (!bad_nxt) begin
                status_q   <= ST_OPEN;
                unlocked_q <= 1'b1;
                fail_q     <= '0;
              end else if (lock_hit) begin
                status_q <= ST_LOCKOUT;
                fail_q   <= FW'(MAX_TRIES);
              end else begin
                status_q <= ST_CLOSED;
                fail_q   <= fail_q + FW'(1);
              end
            end else begin
              pos_q <= pos_q + PW'(1);
              bad_q <= bad_nxt;
            end
          end
        end
        ST_CLOSED: begin
          if (bus.clear) begin
            status_q     <= ST_ENTER;
            pos_q        <= '0;
            bad_q        <= 1'b0;
            disp_valid_q <= 1'b0;
          end
        end
        ST_OPEN: begin
          if (bus.clear) begin
            // Relock starts a fresh sequence
            status_q     <= ST_ENTER;
            unlocked_q   <= 1'b0;
            pos_q        <= '0;
            bad_q        <= 1'b0;
            disp_valid_q <= 1'b0;
          end else if (bus.enter && bus.prog) begin
            status_q     <= ST_PROG;
            unlocked_q   <= 1'b0;
            pos_q        <= '0;
            disp_valid_q <= 1'b0;
          end
        end
        ST_PROG: begin
          if (bus.clear) begin
            // Abort: shadow is simply never committed
            status_q   <= ST_OPEN;
            unlocked_q <= 1'b1;
            pos_q      <= '0;
          end else if (bus.enter) begin
            shadow_q     <= shadow_nxt;
            disp_digit_q <= bus.digit;
            disp_valid_q <= 1'b1;
            if (last) begin
              code_q     <= shadow_nxt;
              status_q   <= ST_OPEN;
              unlocked_q <= 1'b1;
              pos_q      <= '0;
            end else begin
              pos_q <= pos_q + PW'(1);
            end
          end
        end
        ST_LOCKOUT: begin
          // Inputs ignored; leave on the timer's final cycle
          if (tmr_done || !tmr_busy) begin
            status_q     <= ST_ENTER;
            pos_q        <= '0;
            bad_q        <= 1'b0;
            fail_q       <= '0;
            disp_valid_q <= 1'b0;
          end
        end
        default: begin
          status_q     <= ST_ENTER;
          unlocked_q   <= 1'b0;
          pos_q        <= '0;
          bad_q        <= 1'b0;
          disp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.status     = status_q;
  assign bus.pos        = pos_q;
  assign bus.fail_cnt   = fail_q;
  assign bus.disp_digit = disp_digit_q;
  assign bus.disp_valid = disp_valid_q;
  assign bus.unlocked   = unlocked_q;
endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
Parametrised sequential combination-lock controller, the successor to the fixed 6-digit lock. It takes a configurable code length and digit width, and adds run-time code reprogramming, a failed-attempt counter and a timed lockout. It sits between the debounced switch/key inputs and the HEX status/digit decoder in the board top level.

Parameters:
SEQ_LEN, 6, number of digits in the code (2..16)
DIGIT_W, 4, bits per digit
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, clock cycles spent in LOCKOUT (>=1)
DEFAULT_CODE, 24'h483815, reset code with digit 0 in the MSBs; width is SEQ_LEN*DIGIT_W

Ports:
clk  in  1  clock; all state changes occur on the rising edge
rst  in  1  reset, asynchronous, active-high
enter  in  1  single-cycle digit strobe (active-high, pre-inverted key)
clear  in  1  single-cycle retry/relock/abort strobe
prog  in  1  level; sampled together with enter while in OPEN
digit  in  DIGIT_W  current digit value
status  out  3  state code: 0 ENTER, 1 OPEN, 2 CLOSED, 3 LOCKOUT, 4 PROG
pos  out  clog2(SEQ_LEN+1)  number of digits accepted in the current sequence
fail_cnt  out  clog2(MAX_TRIES+1)  consecutive failed attempts
disp_digit  out  DIGIT_W  last digit accepted
disp_valid  out  1  high once a digit has been accepted since the last sequence start
unlocked  out  1  equals (status==OPEN)

Behaviour:
- All outputs are registered. They update on the edge that samples the strobe, so there is zero extra latency.
- Async reset values:
  - status=ENTER, pos=0, fail_cnt=0, disp_digit=0, disp_valid=0, unlocked=0
  - internal bad flag=0, code register=DEFAULT_CODE, lockout timer=0
- Priority rules:
  - clear beats enter when both are high in the same cycle.
  - In LOCKOUT, all inputs are ignored.
- ENTER state, on each enter:
  - Compare digit against code slice[pos]; set bad |= mismatch.
  - Increment pos; set disp_digit=digit and disp_valid=1.
  - A mismatch is never revealed early; the full SEQ_LEN digits are always consumed.
- ENTER, on the strobe that brings pos to SEQ_LEN (final-digit evaluation includes the current digit):
  - No mismatch: go to OPEN, fail_cnt=0.
  - Otherwise, if fail_cnt+1==MAX_TRIES: go to LOCKOUT, timer=LOCKOUT_CYCLES-1, fail_cnt saturates at MAX_TRIES.
  - Otherwise: fail_cnt+=1, go to CLOSED.
- ENTER, on clear: pos=0, bad=0, disp_valid=0; fail_cnt is unchanged.
- CLOSED: enter is ignored. clear goes to ENTER with pos=0, bad=0, disp_valid=0.
- OPEN:
  - clear relocks: go to ENTER, pos=0.
  - enter with prog=1: go to PROG, pos=0, disp_valid=0.
  - enter with prog=0: ignored.
- PROG:
  - Each enter writes digit into shadow slice[pos] and increments pos.
  - On the SEQ_LEN-th digit, the shadow is copied into the code register in the same edge and the block returns to OPEN.
  - clear aborts: code register unchanged, go to OPEN.
- LOCKOUT:
  - The timer decrements every cycle.
  - On the cycle the timer is 0, go to ENTER with pos=0, bad=0, fail_cnt=0, disp_valid=0.
  - Total dwell in LOCKOUT is exactly LOCKOUT_CYCLES cycles.
- pos never exceeds SEQ_LEN. It returns to 0 on every state change.
- The code register is volatile: reset mid-operation (including mid-PROG) restores DEFAULT_CODE and discards the shadow.
- Undefined status encodings (5..7) recover to ENTER on the next edge.

Decomposition:
- Package code_lock_pkg holds:
  - status encoding constants ST_ENTER, ST_OPEN, ST_CLOSED, ST_LOCKOUT, ST_PROG
  - the width function for pos and fail_cnt
- Sub-module lockout_timer:
  - Loadable down-counter of width clog2(LOCKOUT_CYCLES).
  - Ports clk, rst, load, load_val, busy, done.
- Digit compare and shadow storage stay in code_lock_ctrl.

Test Plan:
- Reset, then enter 4,8,3,8,1,5 -> status=OPEN after the 6th strobe, unlocked=1, fail_cnt=0, disp_digit=5.
- Enter 4,8,9,8,1,5 -> status stays ENTER with pos=1..5; after the 6th strobe status=CLOSED, fail_cnt=1; clear -> ENTER, pos=0.
- Three wrong sequences (clear between them) -> third completes into LOCKOUT with fail_cnt=3; enter/clear pulses ignored for 16 cycles; cycle 17 -> ENTER, fail_cnt=0.
- From OPEN: prog=1 plus enter, then enter 1,1,1,1,1,1 -> OPEN; clear, enter 4,8,3,8,1,5 -> CLOSED; clear, enter 1,1,1,1,1,1 -> OPEN.
- Assert rst asynchronously mid-PROG after 3 digits -> immediate status=ENTER, pos=0; code 4,8,3,8,1,5 opens again.
- enter and clear high together in ENTER with pos=2 -> pos=0, digit not recorded; in PROG the same stimulus -> OPEN with code unchanged.
